// File: rtl/tpg_timing_pkg.sv
// tpg_timing_pkg: register map and controller state encoding shared by the timing controller.
package tpg_timing_pkg;
    localparam int A_HS_START   = 0;
    localparam int A_HS_END     = 1;
    localparam int A_HACT_START = 2;
    localparam int A_HACT_END   = 3;
    localparam int A_H_END      = 4;
    localparam int A_VS_START   = 5;
    localparam int A_VS_END     = 6;
    localparam int A_VACT_START = 7;
    localparam int A_VACT_END   = 8;
    localparam int A_V_END      = 9;
    localparam int NUM_REGS     = 10;
    localparam int NUM_H        = 5;
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
endpackage

// File: rtl/tpg_timing_check.sv
// tpg_timing_check: combinational sanity check of a horizontal/vertical timing set.
module tpg_timing_check #(
    parameter int H_BITS = 12,
    parameter int V_BITS = 12
) (
    input  logic [H_BITS-1:0] hs_start,
    input  logic [H_BITS-1:0] hs_end,
    input  logic [H_BITS-1:0] hact_start,
    input  logic [H_BITS-1:0] hact_end,
    input  logic [H_BITS-1:0] h_end,
    input  logic [V_BITS-1:0] vs_start,
    input  logic [V_BITS-1:0] vs_end,
    input  logic [V_BITS-1:0] vact_start,
    input  logic [V_BITS-1:0] vact_end,
    input  logic [V_BITS-1:0] v_end,
    output logic              valid
);
    assign valid = (hs_start < hs_end) && (hs_end <= h_end) &&
                   (hact_start < hact_end) && (hact_end <= h_end) &&
                   (vs_start < vs_end) && (vs_end <= v_end) &&
                   (vact_start < vact_end) && (vact_end <= v_end);
endmodule

// File: rtl/tpg_timing_ctrl.sv
// tpg_timing_ctrl: shadow/active timing registers, frame-boundary updates and run control for the TPG.
// Optional watchdog on stuck frame boundaries: define TPG_TIMING_WDOG_EN.
module tpg_timing_ctrl
    import tpg_timing_pkg::*;
#(
    parameter int H_BITS      = 12,
    parameter int V_BITS      = 12,
    parameter int FC_BITS     = 16,
    parameter int WDOG_CYCLES = 4194304
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_wr,
    input  logic [3:0]         cfg_addr,
    input  logic [15:0]        cfg_wdata,
    input  logic               cfg_commit,
    input  logic               start,
    input  logic               stop,
    input  logic               tpg_vs,
    output logic [H_BITS-1:0]  tHS_START,
    output logic [H_BITS-1:0]  tHS_END,
    output logic [H_BITS-1:0]  tHACT_START,
    output logic [H_BITS-1:0]  tHACT_END,
    output logic [H_BITS-1:0]  tH_END,
    output logic [V_BITS-1:0]  tVS_START,
    output logic [V_BITS-1:0]  tVS_END,
    output logic [V_BITS-1:0]  tVACT_START,
    output logic [V_BITS-1:0]  tVACT_END,
    output logic [V_BITS-1:0]  tV_END,
    output logic               tpg_en,
    output logic               cfg_busy,
    output logic               cfg_err,
    output logic [FC_BITS-1:0] frame_cnt,
    output logic               wdog_err
);
    logic [H_BITS-1:0] sh_h [NUM_H];
    logic [H_BITS-1:0] act_h [NUM_H];
    logic [V_BITS-1:0] sh_v [NUM_H];
    logic [V_BITS-1:0] act_v [NUM_H];
    logic [2:0] idx;
    logic vs_q, pend, active_valid, stop_q, valid, fe, bnd, force_b, unused;
    state_t state, state_d;

    tpg_timing_check #(.H_BITS(H_BITS), .V_BITS(V_BITS)) u_check (
        .hs_start(sh_h[A_HS_START]), .hs_end(sh_h[A_HS_END]),
        .hact_start(sh_h[A_HACT_START]), .hact_end(sh_h[A_HACT_END]), .h_end(sh_h[A_H_END]),
        .vs_start(sh_v[A_VS_START-NUM_H]), .vs_end(sh_v[A_VS_END-NUM_H]),
        .vact_start(sh_v[A_VACT_START-NUM_H]), .vact_end(sh_v[A_VACT_END-NUM_H]),
        .v_end(sh_v[A_V_END-NUM_H]), .valid(valid)
    );

    assign unused   = ^cfg_wdata;
    assign idx      = cfg_addr < 4'(NUM_H) ? cfg_addr[2:0] : 3'(cfg_addr - 4'(NUM_H));
    assign fe       = tpg_en && tpg_vs && !vs_q;
    assign bnd      = fe || force_b;
    assign tpg_en   = state != IDLE;
    assign cfg_busy = pend;

    assign {tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END} =
        {act_h[A_HS_START], act_h[A_HS_END], act_h[A_HACT_START], act_h[A_HACT_END], act_h[A_H_END]};
    assign {tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END} =
        {act_v[A_VS_START-NUM_H], act_v[A_VS_END-NUM_H], act_v[A_VACT_START-NUM_H],
         act_v[A_VACT_END-NUM_H], act_v[A_V_END-NUM_H]};

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     state_d = (start && active_valid) ? RUN : IDLE;
            RUN:      state_d = (stop || stop_q) ? STOPPING : RUN;
            STOPPING: state_d = bnd ? IDLE : STOPPING;
            default:  state_d = IDLE;
        endcase
    end

    // A stop arriving together with an accepted start is replayed once RUN is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            vs_q         <= 1'b0;
            stop_q       <= 1'b0;
            pend         <= 1'b0;
            active_valid <= 1'b0;
            cfg_err      <= 1'b0;
            frame_cnt    <= '0;
            for (int i = 0; i < NUM_H; i++) begin
                sh_h[i]  <= '0;
                act_h[i] <= '0;
                sh_v[i]  <= '0;
                act_v[i] <= '0;
            end
        end else begin
            state  <= state_d;
            vs_q   <= tpg_vs;
            stop_q <= (state == IDLE) && start && stop && active_valid;
            if (cfg_wr && !pend && cfg_addr < 4'(NUM_REGS)) begin
                if (cfg_addr < 4'(NUM_H)) sh_h[idx] <= cfg_wdata[H_BITS-1:0];
                else sh_v[idx] <= cfg_wdata[V_BITS-1:0];
            end
            if (fe) frame_cnt <= frame_cnt + 1'b1;
            if (bnd && pend) begin
                act_h <= sh_h;
                act_v <= sh_v;
                pend  <= 1'b0;
            end
            // Commits are only evaluated with nothing pending, so they never race the boundary load.
            if (cfg_commit && !pend) begin
                cfg_err <= !valid;
                if (valid && state == IDLE) begin
                    act_h        <= sh_h;
                    act_v        <= sh_v;
                    active_valid <= 1'b1;
                end
                if (valid && state != IDLE) pend <= 1'b1;
            end
        end
    end

`ifdef TPG_TIMING_WDOG_EN
    localparam int WB = WDOG_CYCLES > 1 ? $clog2(WDOG_CYCLES) : 1;
    logic [WB-1:0] wcnt;
    logic waiting, werr;
    assign waiting  = pend || state == STOPPING;
    assign force_b  = waiting && wcnt == WB'(WDOG_CYCLES - 1);
    assign wdog_err = werr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
            werr <= 1'b0;
        end else begin
            wcnt <= (fe || !waiting || force_b) ? '0 : wcnt + 1'b1;
            if (force_b) werr <= 1'b1;
        end
    end
`else
    assign force_b  = 1'b0;
    assign wdog_err = WDOG_CYCLES < 0;
`endif
endmodule

// File: tb/tb_tpg_timing_ctrl.sv
// tb_tpg_timing_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_tpg_timing_ctrl;
    localparam int HB = 12, VB = 12, FCB = 4, WD = 16;
    logic clk = 0, rst_n = 0, cfg_wr = 0, cfg_commit = 0, start = 0, stop = 0, tpg_vs = 0;
    logic [3:0] cfg_addr = 0;
    logic [15:0] cfg_wdata = 0;
    logic [HB-1:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
    logic [VB-1:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
    logic tpg_en, cfg_busy, cfg_err, wdog_err;
    logic [FCB-1:0] frame_cnt;
    int n_cmp = 0, n_bad = 0;
    int a_set [10] = '{2, 6, 8, 40, 48, 1, 3, 4, 30, 32};
    logic [11:0] m_sh [10];
    logic [11:0] m_act [10];
    bit m_avalid, m_err, m_pend;
    int m_st, m_fc;

    always #5 clk = ~clk;

    tpg_timing_ctrl #(.H_BITS(HB), .V_BITS(VB), .FC_BITS(FCB), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .start(start), .stop(stop), .tpg_vs(tpg_vs),
        .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
        .tHACT_END(tHACT_END), .tH_END(tH_END), .tVS_START(tVS_START), .tVS_END(tVS_END),
        .tVACT_START(tVACT_START), .tVACT_END(tVACT_END), .tV_END(tV_END),
        .tpg_en(tpg_en), .cfg_busy(cfg_busy), .cfg_err(cfg_err), .frame_cnt(frame_cnt),
        .wdog_err(wdog_err)
    );

    function automatic logic [119:0] dut_vec();
        return {tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END,
                tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END};
    endfunction

    function automatic logic [119:0] mod_vec();
        logic [119:0] v = '0;
        for (int i = 0; i < 10; i++) v = {v[107:0], m_act[i]};
        return v;
    endfunction

    function automatic bit set_ok();
        return m_sh[0] < m_sh[1] && m_sh[1] <= m_sh[4] && m_sh[2] < m_sh[3] && m_sh[3] <= m_sh[4] &&
               m_sh[5] < m_sh[6] && m_sh[6] <= m_sh[9] && m_sh[7] < m_sh[8] && m_sh[8] <= m_sh[9];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 10; i++) begin
            m_sh[i] = 0;
            m_act[i] = 0;
        end
        m_avalid = 0; m_err = 0; m_pend = 0; m_st = 0; m_fc = 0;
    endtask

    task automatic m_commit();
        if (!m_pend) begin
            m_err = !set_ok();
            if (!m_err && m_st == 0) begin
                m_act = m_sh;
                m_avalid = 1;
            end else if (!m_err) m_pend = 1;
        end
    endtask

    task automatic m_fe();
        if (m_st != 0) begin
            m_fc = (m_fc + 1) % (1 << FCB);
            if (m_pend) begin
                m_act = m_sh;
                m_pend = 0;
            end
            if (m_st == 2) m_st = 0;
        end
    endtask

    task automatic do_write(input int a, input int d);
        @(negedge clk); cfg_wr = 1; cfg_addr = a[3:0]; cfg_wdata = d[15:0];
        @(negedge clk); cfg_wr = 0;
        if (a < 10 && !m_pend) m_sh[a] = d[11:0];
    endtask

    task automatic do_commit();
        @(negedge clk); cfg_commit = 1;
        @(negedge clk); cfg_commit = 0;
        m_commit();
    endtask

    task automatic do_start();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        if (m_st == 0 && m_avalid) m_st = 1;
    endtask

    task automatic do_stop();
        @(negedge clk); stop = 1;
        @(negedge clk); stop = 0;
        if (m_st == 1) m_st = 2;
    endtask

    task automatic do_vs();
        @(negedge clk); tpg_vs = 1;
        @(negedge clk); tpg_vs = 0;
        m_fe();
    endtask

    task automatic test_reset();
        m_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (dut_vec() !== 120'd0) begin n_bad++; $display("FAIL reset_timing: got %0h want 0", dut_vec()); end
        n_cmp++; if ({tpg_en, cfg_busy, cfg_err, wdog_err} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {tpg_en, cfg_busy, cfg_err, wdog_err}); end
        n_cmp++; if (frame_cnt !== '0) begin n_bad++; $display("FAIL reset_fc: got %0d want 0", frame_cnt); end
        rst_n = 1;
    endtask

    task automatic test_commit_idle();
        for (int i = 0; i < 10; i++) do_write(i, a_set[i]);
        n_cmp++; if (dut_vec() !== 120'd0) begin n_bad++; $display("FAIL precommit_timing: got %0h want 0", dut_vec()); end
        do_commit();
        n_cmp++; if (dut_vec() !== mod_vec()) begin n_bad++; $display("FAIL idle_commit: got %0h want %0h", dut_vec(), mod_vec()); end
        n_cmp++; if ({cfg_busy, cfg_err} !== 2'b00) begin n_bad++; $display("FAIL idle_commit_flags: got %b want 00", {cfg_busy, cfg_err}); end
        @(negedge clk); start = 1;
        n_cmp++; if (tpg_en !== 1'b0) begin n_bad++; $display("FAIL start_early: got %b want 0", tpg_en); end
        @(negedge clk); start = 0; m_st = 1;
        n_cmp++; if (tpg_en !== 1'b1) begin n_bad++; $display("FAIL start_en: got %b want 1", tpg_en); end
    endtask

    task automatic test_run_commit();
        do_write(3, 44);
        do_commit();
        n_cmp++; if (cfg_busy !== 1'b1) begin n_bad++; $display("FAIL run_busy: got %b want 1", cfg_busy); end
        n_cmp++; if (tHACT_END !== 12'd40) begin n_bad++; $display("FAIL run_hold: got %0d want 40", tHACT_END); end
        do_write(3, 10);
        @(negedge clk); tpg_vs = 1;
        n_cmp++; if (tHACT_END !== 12'd40 || cfg_busy !== 1'b1) begin n_bad++; $display("FAIL pre_fe: got %0d/%b want 40/1", tHACT_END, cfg_busy); end
        @(negedge clk); tpg_vs = 0; m_fe();
        n_cmp++; if (tHACT_END !== 12'd44 || cfg_busy !== 1'b0) begin n_bad++; $display("FAIL post_fe: got %0d/%b want 44/0", tHACT_END, cfg_busy); end
        n_cmp++; if (frame_cnt !== 4'd1) begin n_bad++; $display("FAIL post_fe_fc: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_stop();
        do_stop();
        repeat (3) begin
            @(negedge clk);
            n_cmp++; if (tpg_en !== 1'b1) begin n_bad++; $display("FAIL stop_hold: got %b want 1", tpg_en); end
        end
        @(negedge clk); tpg_vs = 1;
        n_cmp++; if (tpg_en !== 1'b1) begin n_bad++; $display("FAIL stop_fe_en: got %b want 1", tpg_en); end
        @(negedge clk); tpg_vs = 0; m_fe();
        n_cmp++; if (tpg_en !== 1'b0 || frame_cnt !== 4'd2) begin n_bad++; $display("FAIL stop_done: got %b/%0d want 0/2", tpg_en, frame_cnt); end
    endtask

    task automatic test_invalid();
        do_write(3, 50);
        do_commit();
        n_cmp++; if (cfg_err !== 1'b1 || tHACT_END !== 12'd44) begin n_bad++; $display("FAIL bad_commit: got %b/%0d want 1/44", cfg_err, tHACT_END); end
        do_start();
        n_cmp++; if (tpg_en !== 1'b1 || dut_vec() !== mod_vec()) begin n_bad++; $display("FAIL bad_then_start: got %b/%0h want 1/%0h", tpg_en, dut_vec(), mod_vec()); end
    endtask

    task automatic test_stop_commit();
        do_write(3, 42);
        @(negedge clk); stop = 1; cfg_commit = 1;
        @(negedge clk); stop = 0; cfg_commit = 0; m_commit(); m_st = 2;
        n_cmp++; if ({tpg_en, cfg_busy, cfg_err} !== 3'b110) begin n_bad++; $display("FAIL stop_commit: got %b want 110", {tpg_en, cfg_busy, cfg_err}); end
        do_vs();
        n_cmp++; if (tpg_en !== 1'b0 || cfg_busy !== 1'b0 || tHACT_END !== 12'd42) begin n_bad++; $display("FAIL stop_commit_fe: got %b/%b/%0d want 0/0/42", tpg_en, cfg_busy, tHACT_END); end
    endtask

    task automatic test_start_stop();
        @(negedge clk); start = 1; stop = 1;
        @(negedge clk); start = 0; stop = 0; m_st = 2;
        n_cmp++; if (tpg_en !== 1'b1) begin n_bad++; $display("FAIL startstop_en: got %b want 1", tpg_en); end
        @(negedge clk);
        n_cmp++; if (tpg_en !== 1'b1) begin n_bad++; $display("FAIL startstop_hold: got %b want 1", tpg_en); end
        do_vs();
        n_cmp++; if (tpg_en !== 1'b0 || frame_cnt !== 4'(m_fc)) begin n_bad++; $display("FAIL startstop_end: got %b/%0d want 0/%0d", tpg_en, frame_cnt, m_fc); end
    endtask

    task automatic test_wrap();
        do_start();
        for (int i = 0; i < 18; i++) begin
            do_vs();
            n_cmp++; if (frame_cnt !== 4'(m_fc)) begin n_bad++; $display("FAIL wrap_fc: got %0d want %0d", frame_cnt, m_fc); end
        end
        do_stop();
        do_vs();
        repeat (2) @(negedge clk);
        n_cmp++; if (frame_cnt !== 4'(m_fc) || tpg_en !== 1'b0) begin n_bad++; $display("FAIL idle_fc_hold: got %0d/%b want %0d/0", frame_cnt, tpg_en, m_fc); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            int op = $urandom_range(0, 6);
            int a = $urandom_range(0, 11);
            int d = (a < 10 ? a_set[a] : 0) + $urandom_range(0, 10) - 5;
            if (d < 0) d = 0;
            d = d | ($urandom_range(0, 1) << 13);
            case (op)
                0, 1: do_write(a, d);
                2: do_commit();
                3: do_start();
                4: do_stop();
                5: do_vs();
                default: @(negedge clk);
            endcase
            n_cmp++; if (dut_vec() !== mod_vec()) begin n_bad++; $display("FAIL rnd_timing op%0d: got %0h want %0h", op, dut_vec(), mod_vec()); end
            n_cmp++; if ({tpg_en, cfg_busy, cfg_err} !== {m_st != 0, m_pend, m_err}) begin n_bad++; $display("FAIL rnd_flags op%0d: got %b want %b", op, {tpg_en, cfg_busy, cfg_err}, {m_st != 0, m_pend, m_err}); end
            n_cmp++; if (frame_cnt !== 4'(m_fc)) begin n_bad++; $display("FAIL rnd_fc op%0d: got %0d want %0d", op, frame_cnt, m_fc); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) do_write(i, a_set[i]);
        do_commit();
        do_start();
        do_vs();
        @(negedge clk); #2 rst_n = 0; #1;
        n_cmp++; if (dut_vec() !== 120'd0 || {tpg_en, cfg_busy, cfg_err} !== 3'b0 || frame_cnt !== '0) begin n_bad++; $display("FAIL mid_reset: got %0h/%b/%0d want 0", dut_vec(), {tpg_en, cfg_busy, cfg_err}, frame_cnt); end
        m_reset();
        @(negedge clk); rst_n = 1;
        do_commit();
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL shadow_lost: got %b want 1", cfg_err); end
    endtask

`ifdef TPG_TIMING_WDOG_EN
    task automatic test_wdog();
        int cyc = 0;
        for (int i = 0; i < 10; i++) do_write(i, a_set[i]);
        do_commit();
        do_start();
        @(negedge clk); stop = 1;
        @(negedge clk); stop = 0; cyc = 1;
        while (tpg_en && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (cyc < 15 || cyc > 17) begin n_bad++; $display("FAIL wdog_time: got %0d want 16", cyc); end
        n_cmp++; if (wdog_err !== 1'b1 || frame_cnt !== 4'(m_fc)) begin n_bad++; $display("FAIL wdog_flag: got %b/%0d want 1/%0d", wdog_err, frame_cnt, m_fc); end
    endtask
`endif

    initial begin
        test_reset();
        test_commit_idle();
`ifdef TPG_TIMING_WDOG_EN
        do_stop();
        do_vs();
        test_wdog();
`else
        test_run_commit();
        test_stop();
        test_invalid();
        test_stop_commit();
        test_start_stop();
        test_wrap();
        test_random();
        test_reset_mid();
        n_cmp++; if (wdog_err !== 1'b0) begin n_bad++; $display("FAIL wdog_tied: got %b want 0", wdog_err); end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
